// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction issue controller.
// Holds the opcode set, the instruction payload layout and the decode that
// says which source operands an opcode actually reads.
package pipe_pkg;

  localparam int unsigned REG_W    = 4;
  localparam int unsigned FUNC_W   = 4;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned NUM_REGS = 16;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_ADD = 4'd0,
    FUNC_SUB = 4'd1,
    FUNC_AND = 4'd2,
    FUNC_NOT = 4'd3,
    FUNC_LDB = 4'd4,
    FUNC_OR  = 4'd5,
    FUNC_XOR = 4'd6,
    FUNC_MUL = 4'd7,
    FUNC_SHL = 4'd8,
    FUNC_STB = 4'd9,
    FUNC_SHR = 4'd10,
    FUNC_SLA = 4'd11
  } func_e;

  // Highest legal opcode; anything above is dropped at the queue input.
  localparam logic [FUNC_W-1:0] FUNC_MAX = 4'd11;

  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [FUNC_W-1:0] func;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  typedef struct packed {
    logic rs1;
    logic rs2;
  } opnd_use_t;

  // Which source registers an opcode reads; unread operands are never hazards.
  function automatic opnd_use_t operand_use(input logic [FUNC_W-1:0] func);
    opnd_use_t u;
    u.rs1 = 1'b1;
    u.rs2 = 1'b1;
    case (func)
      FUNC_NOT, FUNC_SHL, FUNC_SHR, FUNC_SLA: u.rs2 = 1'b0;
      FUNC_LDB, FUNC_STB:                     u.rs1 = 1'b0;
      default: ;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-register write-back scoreboard.
// Ports: clk_i/rst_i (sync, active-high); set_i/set_idx_i load WB_LAT into
// the counter of the register being written; q1_idx_i/q2_idx_i query two
// registers, busy1_o/busy2_o report a write still pending on them.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned WB_LAT = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  logic [REG_W-1:0] set_idx_i,
  input  logic [REG_W-1:0] q1_idx_i,
  input  logic [REG_W-1:0] q2_idx_i,
  output logic             busy1_o,
  output logic             busy2_o
);

  localparam int unsigned CNT_W = (WB_LAT < 2) ? 1 : $clog2(WB_LAT + 1);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];

  // A new write reloads its counter; all other pending writes age by one.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (set_i && (set_idx_i == REG_W'(i))) begin
        cnt_d[i] = CNT_W'(WB_LAT);
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst_i) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign busy1_o = (cnt_q[q1_idx_i] != '0);
  assign busy2_o = (cnt_q[q2_idx_i] != '0);

endmodule

// File: rtl/pipe_issue_ctrl.sv
// In-order instruction queue with RAW hazard interlock for a 4-stage pipe.
// Ports: clk/rst (sync, active-high); in_* offer an instruction, in_ready
// accepts it; flush empties the queue; iss_* present the head instruction
// to the pipe (zero when iss_valid is low); stall flags a hazard-blocked
// head; illegal_err pulses after an out-of-range opcode is dropped;
// occupancy is the number of queued entries.
module pipe_issue_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WB_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [REG_W-1:0]        in_rs1,
  input  logic [REG_W-1:0]        in_rs2,
  input  logic [REG_W-1:0]        in_rd,
  input  logic [FUNC_W-1:0]       in_func,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic                    flush,
  output logic                    iss_valid,
  output logic [REG_W-1:0]        iss_rs1,
  output logic [REG_W-1:0]        iss_rs2,
  output logic [REG_W-1:0]        iss_rd,
  output logic [FUNC_W-1:0]       iss_func,
  output logic [ADDR_W-1:0]       iss_addr,
  output logic                    illegal_err,
  output logic                    stall,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  instr_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             illegal_q, illegal_d;

  instr_t    in_instr;
  instr_t    head;
  opnd_use_t head_use;
  logic      head_valid;
  logic      hazard;
  logic      accept;
  logic      accept_legal;
  logic      issue;
  logic      busy1, busy2;

  assign in_instr = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};

  // Input handshake; illegal opcodes are accepted but never stored.
  assign in_ready     = (occ_q < OCC_W'(DEPTH)) && !flush;
  assign accept       = in_valid && in_ready;
  assign accept_legal = accept && (in_func <= FUNC_MAX);
  assign illegal_d    = accept && (in_func > FUNC_MAX);

  // Head decode and RAW check against the scoreboard.
  assign head_valid = (occ_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign head_use   = operand_use(head.func);
  assign hazard     = (head_use.rs1 && busy1) || (head_use.rs2 && busy2);
  assign issue      = head_valid && !hazard && !flush;
  assign stall      = head_valid && hazard && !flush;

  pipe_scoreboard #(
    .WB_LAT (WB_LAT)
  ) u_scoreboard (
    .clk_i     (clk),
    .rst_i     (rst),
    .set_i     (issue),
    .set_idx_i (head.rd),
    .q1_idx_i  (head.rs1),
    .q2_idx_i  (head.rs2),
    .busy1_o   (busy1),
    .busy2_o   (busy2)
  );

  // Issue bus is zeroed whenever nothing is issued.
  always_comb begin
    iss_valid = issue;
    iss_rs1   = '0;
    iss_rs2   = '0;
    iss_rd    = '0;
    iss_func  = '0;
    iss_addr  = '0;
    if (issue) begin
      iss_rs1  = head.rs1;
      iss_rs2  = head.rs2;
      iss_rd   = head.rd;
      iss_func = head.func;
      iss_addr = head.addr;
    end
  end

  // Queue pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (accept_legal) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        occ_d    = occ_d + OCC_W'(1);
      end
      if (issue) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        occ_d    = occ_d - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      illegal_q <= illegal_d;
    end
  end

  // Payload storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (accept_legal) begin
      mem_q[wr_ptr_q] <= in_instr;
    end
  end

  assign illegal_err = illegal_q;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl: hazard interlock, back-to-back issue,
// illegal opcode drop, queue full, operand-use decode, flush and reset.
module tb_pipe_issue_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_rs1, in_rs2, in_rd, in_func;
  logic [7:0] in_addr;
  logic       flush;
  logic       iss_valid;
  logic [3:0] iss_rs1, iss_rs2, iss_rd, iss_func;
  logic [7:0] iss_addr;
  logic       illegal_err;
  logic       stall;
  logic [2:0] occupancy;

  int total;
  int bad;

  pipe_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rd       (in_rd),
    .in_func     (in_func),
    .in_addr     (in_addr),
    .flush       (flush),
    .iss_valid   (iss_valid),
    .iss_rs1     (iss_rs1),
    .iss_rs2     (iss_rs2),
    .iss_rd      (iss_rd),
    .iss_func    (iss_func),
    .iss_addr    (iss_addr),
    .illegal_err (illegal_err),
    .stall       (stall),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic [3:0] func,
                       input logic [7:0] addr);
    in_valid = 1'b1;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
    in_func  = func;
    in_addr  = addr;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_rs1   = '0;
    in_rs2   = '0;
    in_rd    = '0;
    in_func  = '0;
    in_addr  = '0;
    flush    = 1'b0;
  endtask

  task automatic settle(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    #1;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL reset_iss_valid: got %0b want 0", iss_valid); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", stall); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    total++; if (illegal_err !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %0b want 0", illegal_err); end
  endtask

  // ADD r10=r3+r5 then SUB reading r10: SUB issues 3 cycles later, 2 stall cycles.
  task automatic test_raw();
    int cyc;
    int stalls;
    bit found;
    offer(4'd3, 4'd5, 4'd10, 4'd0, 8'h10);
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL raw_same_cycle_issue: got %0b want 0", iss_valid); end
    step();
    offer(4'd10, 4'd0, 4'd11, 4'd1, 8'h11);
    #1;
    total++; if (iss_valid !== 1'b1 || iss_rd !== 4'd10) begin bad++; $display("FAIL raw_add_issue: valid=%0b rd=%0d want 1/10", iss_valid, iss_rd); end
    step();
    idle();
    cyc = 1;
    stalls = 0;
    found = 1'b0;
    while (!found && cyc < 10) begin
      #1;
      if (iss_valid === 1'b1) begin
        found = 1'b1;
      end else begin
        if (stall === 1'b1) stalls++;
        step();
        cyc++;
      end
    end
    total++; if (!found || cyc != 3) begin bad++; $display("FAIL raw_sub_latency: got %0d want 3 (found=%0b)", cyc, found); end
    total++; if (stalls != 2) begin bad++; $display("FAIL raw_stall_cycles: got %0d want 2", stalls); end
    total++; if (iss_rs1 !== 4'd10 || iss_func !== 4'd1) begin bad++; $display("FAIL raw_sub_fields: rs1=%0d func=%0d want 10/1", iss_rs1, iss_func); end
    step();
    settle(3);
  endtask

  // Four independent instructions issue on consecutive cycles, no stall.
  task automatic test_back_to_back();
    logic [3:0] rds [4];
    int cycs [4];
    int n;
    int stalls;
    n = 0;
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      rds[k] = '0;
      cycs[k] = -1;
    end
    for (int c = 0; c < 8; c++) begin
      if (c < 4) offer(4'(c + 5), 4'(c + 5), 4'(c + 1), 4'd0, 8'(c));
      else idle();
      #1;
      if (iss_valid === 1'b1) begin
        if (n < 4) begin
          rds[n] = iss_rd;
          cycs[n] = c;
        end
        n++;
      end
      if (stall === 1'b1) stalls++;
      step();
    end
    total++; if (n != 4) begin bad++; $display("FAIL b2b_issue_count: got %0d want 4", n); end
    total++; if (stalls != 0) begin bad++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
    for (int k = 0; k < 4; k++) begin
      total++; if (cycs[k] != k + 1 || rds[k] !== 4'(k + 1)) begin bad++; $display("FAIL b2b_slot%0d: cycle=%0d rd=%0d want %0d/%0d", k, cycs[k], rds[k], k + 1, k + 1); end
    end
    settle(3);
  endtask

  // Opcode 13 is accepted, dropped, and flagged for exactly one cycle.
  task automatic test_illegal();
    offer(4'd1, 4'd2, 4'd3, 4'd13, 8'h00);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL illegal_in_ready: got %0b want 1", in_ready); end
    step();
    idle();
    #1;
    total++; if (illegal_err !== 1'b1) begin bad++; $display("FAIL illegal_pulse: got %0b want 1", illegal_err); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL illegal_occ: got %0d want 0", occupancy); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL illegal_no_issue: got %0b want 0", iss_valid); end
    step();
    #1;
    total++; if (illegal_err !== 1'b0) begin bad++; $display("FAIL illegal_pulse_end: got %0b want 0", illegal_err); end
    total++; if (occupancy !== 3'd0 || iss_valid !== 1'b0) begin bad++; $display("FAIL illegal_after: occ=%0d valid=%0b want 0/0", occupancy, iss_valid); end
    settle(1);
  endtask

  // Chain of dependents fills the queue; the next offer waits for an issue.
  task automatic test_full();
    int k;
    offer(4'd0, 4'd0, 4'd1, 4'd0, 8'h00);
    step();
    offer(4'd1, 4'd0, 4'd2, 4'd3, 8'h00);
    #1;
    total++; if (iss_valid !== 1'b1 || iss_rd !== 4'd1) begin bad++; $display("FAIL full_prod_issue: valid=%0b rd=%0d want 1/1", iss_valid, iss_rd); end
    step();
    offer(4'd2, 4'd0, 4'd3, 4'd3, 8'h00);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL full_head_stall: got %0b want 1", stall); end
    step();
    offer(4'd3, 4'd0, 4'd4, 4'd3, 8'h00);
    step();
    offer(4'd4, 4'd0, 4'd5, 4'd3, 8'h00);
    #1;
    total++; if (iss_valid !== 1'b1 || iss_rd !== 4'd2) begin bad++; $display("FAIL full_d1_issue: valid=%0b rd=%0d want 1/2", iss_valid, iss_rd); end
    step();
    offer(4'd5, 4'd0, 4'd6, 4'd3, 8'h00);
    #1;
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL full_occ3: got %0d want 3", occupancy); end
    step();
    offer(4'd6, 4'd0, 4'd7, 4'd3, 8'h00);
    #1;
    total++; if (in_ready !== 1'b0 || occupancy !== 3'd4) begin bad++; $display("FAIL full_blocked: ready=%0b occ=%0d want 0/4", in_ready, occupancy); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL full_stall: got %0b want 1", stall); end
    step();
    #1;
    total++; if (in_ready !== 1'b0 || iss_valid !== 1'b1 || iss_rd !== 4'd3) begin bad++; $display("FAIL full_head_issue: ready=%0b valid=%0b rd=%0d want 0/1/3", in_ready, iss_valid, iss_rd); end
    step();
    #1;
    total++; if (in_ready !== 1'b1 || occupancy !== 3'd3) begin bad++; $display("FAIL full_reopen: ready=%0b occ=%0d want 1/3", in_ready, occupancy); end
    step();
    idle();
    k = 0;
    while (occupancy !== 3'd0 && k < 40) begin
      step();
      k++;
    end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL full_drain: occ=%0d after %0d cycles want 0", occupancy, k); end
    settle(3);
  endtask

  // SLA reads rs1 only: busy rs2 must not hold it once rs1 is free.
  task automatic test_sla();
    offer(4'd0, 4'd0, 4'd7, 4'd0, 8'hA5);
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL sla_prod_early: got %0b want 0", iss_valid); end
    step();
    offer(4'd0, 4'd0, 4'd3, 4'd0, 8'h00);
    #1;
    total++; if (iss_valid !== 1'b1 || iss_addr !== 8'hA5) begin bad++; $display("FAIL sla_prod_addr: valid=%0b addr=%0h want 1/a5", iss_valid, iss_addr); end
    step();
    offer(4'd7, 4'd3, 4'd8, 4'd11, 8'h5A);
    #1;
    total++; if (iss_valid !== 1'b1 || iss_rd !== 4'd3) begin bad++; $display("FAIL sla_prod2: valid=%0b rd=%0d want 1/3", iss_valid, iss_rd); end
    step();
    idle();
    #1;
    total++; if (stall !== 1'b1 || iss_valid !== 1'b0) begin bad++; $display("FAIL sla_r7_stall: stall=%0b valid=%0b want 1/0", stall, iss_valid); end
    total++; if (iss_addr !== 8'h00 || iss_rd !== 4'd0) begin bad++; $display("FAIL sla_idle_bus: addr=%0h rd=%0d want 0/0", iss_addr, iss_rd); end
    step();
    #1;
    total++; if (iss_valid !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL sla_issue: valid=%0b stall=%0b want 1/0", iss_valid, stall); end
    total++; if (iss_func !== 4'd11 || iss_rs2 !== 4'd3 || iss_addr !== 8'h5A) begin bad++; $display("FAIL sla_fields: func=%0d rs2=%0d addr=%0h want 11/3/5a", iss_func, iss_rs2, iss_addr); end
    step();
    settle(3);
  endtask

  // Flush with three queued, then reset mid-stream clears queue and hazards.
  task automatic test_flush_reset();
    offer(4'd0, 4'd0, 4'd1, 4'd0, 8'h00);
    step();
    offer(4'd1, 4'd0, 4'd2, 4'd3, 8'h00);
    step();
    offer(4'd0, 4'd0, 4'd9, 4'd0, 8'h00);
    step();
    offer(4'd0, 4'd0, 4'd10, 4'd0, 8'h00);
    step();
    offer(4'd0, 4'd0, 4'd11, 4'd0, 8'h00);
    flush = 1'b1;
    #1;
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL flush_pre_occ: got %0d want 3", occupancy); end
    total++; if (iss_valid !== 1'b0 || in_ready !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL flush_gating: valid=%0b ready=%0b stall=%0b want 0/0/0", iss_valid, in_ready, stall); end
    step();
    idle();
    #1;
    total++; if (occupancy !== 3'd0 || iss_valid !== 1'b0) begin bad++; $display("FAIL flush_empty: occ=%0d valid=%0b want 0/0", occupancy, iss_valid); end
    offer(4'd0, 4'd0, 4'd5, 4'd0, 8'h00);
    step();
    rst = 1'b1;
    offer(4'd0, 4'd0, 4'd12, 4'd0, 8'h00);
    #1;
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL rst_pre_occ: got %0d want 1", occupancy); end
    step();
    rst = 1'b0;
    offer(4'd5, 4'd0, 4'd8, 4'd3, 8'h00);
    #1;
    total++; if (occupancy !== 3'd0 || iss_valid !== 1'b0) begin bad++; $display("FAIL rst_cleared: occ=%0d valid=%0b want 0/0", occupancy, iss_valid); end
    total++; if (in_ready !== 1'b1 || stall !== 1'b0 || illegal_err !== 1'b0) begin bad++; $display("FAIL rst_flags: ready=%0b stall=%0b ill=%0b want 1/0/0", in_ready, stall, illegal_err); end
    step();
    idle();
    #1;
    total++; if (iss_valid !== 1'b1 || iss_rd !== 4'd8 || stall !== 1'b0) begin bad++; $display("FAIL rst_post_issue: valid=%0b rd=%0d stall=%0b want 1/8/0", iss_valid, iss_rd, stall); end
    step();
    settle(3);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    idle();
    test_reset();
    test_raw();
    test_back_to_back();
    test_illegal();
    test_full();
    test_sla();
    test_flush_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
